// File: rtl/alu_operand_stage.sv
// Two-entry registered issue buffer feeding the combinational ALU, with optional
// writeback snooping of held and incoming operands (enable with `define ALU_OPERAND_FWD_EN).
module alu_operand_stage #(
  parameter int unsigned W   = 8,
  parameter int unsigned OPW = 3,
  parameter int unsigned RW  = 3
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           Flush,
  input  logic           InValid,
  output logic           InReady,
  input  logic [W-1:0]   InOpA,
  input  logic [W-1:0]   InOpB,
  input  logic [RW-1:0]  InSrcA,
  input  logic [RW-1:0]  InSrcB,
  input  logic           InImmB,
  input  logic [OPW-1:0] InOP,
  input  logic [RW-1:0]  InDst,
  output logic           OutValid,
  input  logic           OutReady,
  output logic [W-1:0]   InputA,
  output logic [W-1:0]   InputB,
  output logic [OPW-1:0] OP,
  output logic [RW-1:0]  Dst,
  input  logic           FwdValid,
  input  logic [RW-1:0]  FwdDst,
  input  logic [W-1:0]   FwdData,
  output logic [1:0]     Count
);

  localparam int unsigned DEPTH = 2;

  logic [W-1:0]   a_q    [DEPTH];
  logic [W-1:0]   a_d    [DEPTH];
  logic [W-1:0]   b_q    [DEPTH];
  logic [W-1:0]   b_d    [DEPTH];
  logic [RW-1:0]  srca_q [DEPTH];
  logic [RW-1:0]  srca_d [DEPTH];
  logic [RW-1:0]  srcb_q [DEPTH];
  logic [RW-1:0]  srcb_d [DEPTH];
  logic           immb_q [DEPTH];
  logic           immb_d [DEPTH];
  logic [OPW-1:0] op_q   [DEPTH];
  logic [OPW-1:0] op_d   [DEPTH];
  logic [RW-1:0]  dst_q  [DEPTH];
  logic [RW-1:0]  dst_d  [DEPTH];
  logic [1:0]     count_q;
  logic [1:0]     count_d;

  // Operand values after this cycle's writeback snoop
  logic [W-1:0]   fa     [DEPTH];
  logic [W-1:0]   fb     [DEPTH];
  logic [W-1:0]   in_a;
  logic [W-1:0]   in_b;

  logic           push;
  logic           pop;
  logic           wr_slot1;

  assign InReady  = !Reset && (count_q != 2'd2);
  assign OutValid = (count_q != 2'd0);
  assign push     = InValid && InReady;
  assign pop      = OutValid && OutReady;
  assign wr_slot1 = (count_q == 2'd1) && !pop;

  assign InputA = a_q[0];
  assign InputB = b_q[0];
  assign OP     = op_q[0];
  assign Dst    = dst_q[0];
  assign Count  = count_q;

  // Snoop: only occupied slots are updated so empty slots keep reading as zero
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      fa[i] = a_q[i];
      fb[i] = b_q[i];
    end
    in_a = InOpA;
    in_b = InOpB;
`ifdef ALU_OPERAND_FWD_EN
    if (FwdValid) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (count_q > 2'(i)) begin
          if (FwdDst == srca_q[i]) fa[i] = FwdData;
          if (!immb_q[i] && (FwdDst == srcb_q[i])) fb[i] = FwdData;
        end
      end
      if (FwdDst == InSrcA) in_a = FwdData;
      if (!InImmB && (FwdDst == InSrcB)) in_b = FwdData;
    end
`endif
  end

`ifndef ALU_OPERAND_FWD_EN
  logic unused_fwd;
  assign unused_fwd = ^{FwdValid, FwdDst, FwdData, InSrcA, InSrcB, InImmB,
                        srca_q[0], srca_q[1], srcb_q[0], srcb_q[1],
                        immb_q[0], immb_q[1]};
`endif

  // Next-state: flush clears, pop shifts slot 1 down, push fills first free slot
  always_comb begin
    count_d = count_q;
    for (int i = 0; i < DEPTH; i++) begin
      a_d[i]    = fa[i];
      b_d[i]    = fb[i];
      srca_d[i] = srca_q[i];
      srcb_d[i] = srcb_q[i];
      immb_d[i] = immb_q[i];
      op_d[i]   = op_q[i];
      dst_d[i]  = dst_q[i];
    end

    if (Flush) begin
      count_d = 2'd0;
      for (int i = 0; i < DEPTH; i++) begin
        a_d[i]    = '0;
        b_d[i]    = '0;
        srca_d[i] = '0;
        srcb_d[i] = '0;
        immb_d[i] = 1'b0;
        op_d[i]   = '0;
        dst_d[i]  = '0;
      end
    end else begin
      if (pop) begin
        a_d[0]    = fa[1];
        b_d[0]    = fb[1];
        srca_d[0] = srca_q[1];
        srcb_d[0] = srcb_q[1];
        immb_d[0] = immb_q[1];
        op_d[0]   = op_q[1];
        dst_d[0]  = dst_q[1];
        a_d[1]    = '0;
        b_d[1]    = '0;
        srca_d[1] = '0;
        srcb_d[1] = '0;
        immb_d[1] = 1'b0;
        op_d[1]   = '0;
        dst_d[1]  = '0;
      end
      if (push) begin
        if (wr_slot1) begin
          a_d[1]    = in_a;
          b_d[1]    = in_b;
          srca_d[1] = InSrcA;
          srcb_d[1] = InSrcB;
          immb_d[1] = InImmB;
          op_d[1]   = InOP;
          dst_d[1]  = InDst;
        end else begin
          a_d[0]    = in_a;
          b_d[0]    = in_b;
          srca_d[0] = InSrcA;
          srcb_d[0] = InSrcB;
          immb_d[0] = InImmB;
          op_d[0]   = InOP;
          dst_d[0]  = InDst;
        end
      end
      count_d = count_q + 2'(push) - 2'(pop);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      count_q <= 2'd0;
      for (int i = 0; i < DEPTH; i++) begin
        a_q[i]    <= '0;
        b_q[i]    <= '0;
        srca_q[i] <= '0;
        srcb_q[i] <= '0;
        immb_q[i] <= 1'b0;
        op_q[i]   <= '0;
        dst_q[i]  <= '0;
      end
    end else begin
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        a_q[i]    <= a_d[i];
        b_q[i]    <= b_d[i];
        srca_q[i] <= srca_d[i];
        srcb_q[i] <= srcb_d[i];
        immb_q[i] <= immb_d[i];
        op_q[i]   <= op_d[i];
        dst_q[i]  <= dst_d[i];
      end
    end
  end

endmodule
